// File: rtl/mc_cpu_pkg.sv
// mc_cpu_pkg: shared types, opcode encodings and field helpers for the multi-cycle CPU.
// The optional Z/C flag feature is selected in mc_cpu_core by the macro MC_CPU_FLAGS_EN.
package mc_cpu_pkg;

  // state | meaning
  // IDLE   | out of reset, waiting for start
  // FETCH  | register imem[pc]
  // DECODE | read operands from the register file
  // EXEC   | compute result and next pc
  // WB     | write register file, pulse wb_valid, update pc
  // HALT   | stopped by HALT, waiting for start
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  // opcode classes, top two bits of the opcode byte
  localparam logic [1:0] CLS_MVI = 2'b00;
  localparam logic [1:0] CLS_MOV = 2'b01;
  localparam logic [1:0] CLS_ALU = 2'b10;

  // source field value that marks MVI inside class 00
  localparam logic [2:0] SRC_IMM = 3'b110;

  // ALU operation codes (ddd field of class 10)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  // full-byte control opcodes
  localparam logic [7:0] OP_JMP  = 8'hC0;
  localparam logic [7:0] OP_JZ   = 8'hC8;
  localparam logic [7:0] OP_JC   = 8'hD0;
  localparam logic [7:0] OP_HALT = 8'hFF;

  function automatic logic [1:0] op_cls(input logic [7:0] op);
    return op[7:6];
  endfunction

  function automatic logic [2:0] op_dst(input logic [7:0] op);
    return op[5:3];
  endfunction

  function automatic logic [2:0] op_src(input logic [7:0] op);
    return op[2:0];
  endfunction

endpackage

// File: rtl/mc_cpu_alu.sv
// mc_cpu_alu: combinational DW-wide ALU; y = {carry, result}. On SUB the carry bit is the borrow.
module mc_cpu_alu
  import mc_cpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
  output logic [DW:0]   y
);

  // one-level mux over the five defined operations; undefined codes yield zero
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = {1'b0, a} + {1'b0, b};
      ALU_SUB: y = {1'b0, a} - {1'b0, b};
      ALU_AND: y = {1'b0, a & b};
      ALU_OR:  y = {1'b0, a | b};
      ALU_XOR: y = {1'b0, a ^ b};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle register CPU, 4 cycles per instruction, host-loaded instruction RAM.
// Build macro MC_CPU_FLAGS_EN adds Z/C flags written by ALU ops and the JZ/JC instructions.
module mc_cpu_core
  import mc_cpu_pkg::*;
#(
  parameter  int DW         = 8,
  parameter  int IMEM_DEPTH = 128,
  localparam int IW         = 8 + 2 * DW,
  localparam int PCW        = $clog2(IMEM_DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           imem_we,
  input  logic [PCW-1:0] imem_waddr,
  input  logic [IW-1:0]  imem_wdata,
  output logic           busy,
  output logic           halted,
  output logic           wb_valid,
  output logic [2:0]     wb_reg,
  output logic [DW-1:0]  wb_data,
  output logic [PCW-1:0] pc
);

  // the reserved B field is never executed, so the RAM keeps only opcode and A
  localparam int MW = 8 + DW;

  logic [MW-1:0]  imem [IMEM_DEPTH];
  logic           unused_rsvd;

  state_e         state_q, state_d;
  logic           launch, fetch_en, decode_en, exec_en, wb_en;

  logic [PCW-1:0] pc_q, npc_q, pc_inc, jmp_tgt;
  logic [7:0]     ir_op_q;
  logic [DW-1:0]  ir_a_q;
  logic [DW-1:0]  regs_q [8];
  logic [DW-1:0]  opa_q, opb_q, res_q;
  logic [DW:0]    alu_y;

  logic [1:0]     cls;
  logic [2:0]     fld_d, fld_s, dest;
  logic           is_mvi, is_mov, is_alu, is_jmp, is_halt, take_jump, writes;

`ifdef MC_CPU_FLAGS_EN
  logic           z_q, c_q, cy_q;
  logic           is_jz, is_jc;
`else
  logic           unused_cy;
`endif

  assign unused_rsvd = ^imem_wdata[DW-1:0];
  assign pc          = pc_q;

  // host write port; no reset so the program survives rst_n
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata[IW-1:DW];
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic: fixed four-step walk, start only honoured when stopped
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   state_d = DECODE;
      DECODE:  state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = is_halt ? HALT : FETCH;
      HALT:    if (start) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: status flags and per-stage enables
  always_comb begin
    busy      = 1'b0;
    halted    = 1'b0;
    launch    = 1'b0;
    fetch_en  = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    wb_en     = 1'b0;
    case (state_q)
      IDLE:    launch    = start;
      FETCH:   begin busy = 1'b1; fetch_en  = 1'b1; end
      DECODE:  begin busy = 1'b1; decode_en = 1'b1; end
      EXEC:    begin busy = 1'b1; exec_en   = 1'b1; end
      WB:      begin busy = 1'b1; wb_en     = 1'b1; end
      HALT:    begin halted = 1'b1; launch = start; end
      default: ;
    endcase
  end

  // instruction decode from the latched opcode byte
  always_comb begin
    cls     = op_cls(ir_op_q);
    fld_d   = op_dst(ir_op_q);
    fld_s   = op_src(ir_op_q);
    is_mvi  = (cls == CLS_MVI) && (fld_s == SRC_IMM);
    is_mov  = (cls == CLS_MOV);
    is_alu  = (cls == CLS_ALU) && (fld_d <= ALU_XOR);
    is_jmp  = (ir_op_q == OP_JMP);
    is_halt = (ir_op_q == OP_HALT);
    writes  = is_mvi || is_mov || is_alu;
    dest    = is_alu ? 3'd0 : fld_d;
  end

  // next-pc candidates: wrapping increment and jump target taken modulo the RAM depth
  always_comb begin
    pc_inc  = (pc_q == PCW'(IMEM_DEPTH - 1)) ? '0 : pc_q + 1'b1;
    jmp_tgt = PCW'(32'(ir_a_q) % 32'(IMEM_DEPTH));
`ifdef MC_CPU_FLAGS_EN
    is_jz     = (ir_op_q == OP_JZ);
    is_jc     = (ir_op_q == OP_JC);
    take_jump = is_jmp || (is_jz && z_q) || (is_jc && c_q);
`else
    take_jump = is_jmp;
`endif
  end

  mc_cpu_alu #(.DW(DW)) u_alu (
    .a  (opa_q),
    .b  (opb_q),
    .op (fld_d),
    .y  (alu_y)
  );

`ifndef MC_CPU_FLAGS_EN
  assign unused_cy = alu_y[DW];
`endif

  // datapath: one stage active per cycle, writeback pulses wb_valid for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      npc_q    <= '0;
      ir_op_q  <= '0;
      ir_a_q   <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      wb_valid <= 1'b0;
      wb_reg   <= '0;
      wb_data  <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
`ifdef MC_CPU_FLAGS_EN
      z_q  <= 1'b0;
      c_q  <= 1'b0;
      cy_q <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
      if (launch) pc_q <= '0;
      if (fetch_en) begin
        ir_op_q <= imem[pc_q][MW-1:MW-8];
        ir_a_q  <= imem[pc_q][DW-1:0];
      end
      if (decode_en) begin
        opa_q <= is_mvi ? ir_a_q : (is_alu ? regs_q[0] : regs_q[fld_s]);
        opb_q <= regs_q[fld_s];
      end
      if (exec_en) begin
        res_q <= is_alu ? alu_y[DW-1:0] : opa_q;
        npc_q <= is_halt ? pc_q : (take_jump ? jmp_tgt : pc_inc);
`ifdef MC_CPU_FLAGS_EN
        cy_q  <= alu_y[DW];
`endif
      end
      if (wb_en) begin
        pc_q <= npc_q;
        if (writes) begin
          regs_q[dest] <= res_q;
          wb_valid     <= 1'b1;
          wb_reg       <= dest;
          wb_data      <= res_q;
        end
`ifdef MC_CPU_FLAGS_EN
        if (is_alu) begin
          z_q <= (res_q == '0);
          c_q <= cy_q;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_mc_cpu_core.sv
// tb_mc_cpu_core: directed programs; expected writebacks queued at issue, checked by a monitor.
module tb_mc_cpu_core;
  localparam int DW = 8;
  localparam int IMEM_DEPTH = 128;
  localparam int IW = 8 + 2 * DW;
  localparam int PCW = 7;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           imem_we = 1'b0;
  logic [PCW-1:0] imem_waddr = '0;
  logic [IW-1:0]  imem_wdata = '0;
  logic           busy, halted, wb_valid;
  logic [2:0]     wb_reg;
  logic [DW-1:0]  wb_data;
  logic [PCW-1:0] pc;

  int tests_run = 0;
  int tests_failed = 0;
  logic [10:0] exp_q[$];
  int n_cyc;

  always #5 clk = ~clk;

  mc_cpu_core #(.DW(DW), .IMEM_DEPTH(IMEM_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .busy(busy), .halted(halted), .wb_valid(wb_valid),
    .wb_reg(wb_reg), .wb_data(wb_data), .pc(pc)
  );

  function automatic logic [IW-1:0] mvi(input logic [2:0] d, input logic [7:0] a);
    return {2'b00, d, 3'b110, a, 8'h00};
  endfunction
  function automatic logic [IW-1:0] mov(input logic [2:0] d, input logic [2:0] s);
    return {2'b01, d, s, 16'h0000};
  endfunction
  function automatic logic [IW-1:0] alu(input logic [2:0] o, input logic [2:0] s);
    return {2'b10, o, s, 16'h0000};
  endfunction
  function automatic logic [IW-1:0] ctl(input logic [7:0] op, input logic [7:0] a);
    return {op, a, 8'h00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && wb_valid) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL wb_unexpected: got reg %0d data %0d, required no writeback", wb_reg, wb_data);
        end else begin
          e = exp_q.pop_front();
          if ({wb_reg, wb_data} !== e) begin
            tests_failed++;
            $display("FAIL wb_data: got reg %0d data 0x%02h, required reg %0d data 0x%02h",
                     wb_reg, wb_data, e[10:8], e[7:0]);
          end
        end
      end
    end
  endtask

  task automatic load(input int addr, input logic [IW-1:0] w);
    @(negedge clk);
    imem_we = 1'b1;
    imem_waddr = PCW'(addr);
    imem_wdata = w;
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("rst_wb_valid", wb_valid, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_halt(output int n);
    n = 0;
    while (!halted && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    if (!halted) begin
      tests_run++;
      tests_failed++;
      $display("FAIL halt_timeout: got halted=0 after %0d cycles, required halted=1", n);
    end
  endtask

  initial begin
    fork monitor(); join_none

    // 1: reset state and quiet idle
    repeat (3) @(posedge clk);
    #1;
    check("t1_busy_in_rst", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t1_busy", busy, 0);
    check("t1_halted", halted, 0);
    check("t1_pc", pc, 0);
    check("t1_wb_reg", wb_reg, 0);
    check("t1_wb_data", wb_data, 0);

    // 2: MVI/MVI/ADD/HALT, halted 16 cycles after start is taken
    load(0, mvi(3'd0, 8'd5));
    load(1, mvi(3'd1, 8'hFD));
    load(2, alu(3'b000, 3'd1));
    load(3, ctl(8'hFF, 8'h00));
    exp_q.push_back({3'd0, 8'd5});
    exp_q.push_back({3'd1, 8'hFD});
    exp_q.push_back({3'd0, 8'd2});
    pulse_start();
    check("t2_busy", busy, 1);
    wait_halt(n_cyc);
    check("t2_halt_cycles", n_cyc, 16);
    check("t2_pc_hold", pc, 3);
    check("t2_busy_halt", busy, 0);
    check("t2_queue_empty", exp_q.size(), 0);

    // 3: 127 + 1 wraps to -128; Z=0 and C=0 so JZ/JC fall through
    load(0, mvi(3'd0, 8'd127));
    load(1, mvi(3'd1, 8'd1));
    load(2, alu(3'b000, 3'd1));
    load(3, ctl(8'hC8, 8'd20));
    load(4, ctl(8'hD0, 8'd21));
    load(5, ctl(8'hFF, 8'h00));
    load(20, ctl(8'hFF, 8'h00));
    load(21, ctl(8'hFF, 8'h00));
    exp_q.push_back({3'd0, 8'd127});
    exp_q.push_back({3'd1, 8'd1});
    exp_q.push_back({3'd0, 8'h80});
    pulse_start();
    wait_halt(n_cyc);
    check("t3_pc_no_jump", pc, 5);
    check("t3_queue_empty", exp_q.size(), 0);

    // 4: JMP 0x7F, MOV r2,r0 at 127, pc wraps to 0; start while busy ignored
    load(0, ctl(8'hC0, 8'h7F));
    load(127, mov(3'd2, 3'd0));
    exp_q.push_back({3'd2, 8'h80});
    pulse_start();
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t4_pc_jmp", pc, 127);
    check("t4_busy", busy, 1);
    repeat (4) @(posedge clk);
    #1 check("t4_pc_wrap", pc, 0);
    do_reset();
    check("t4_queue_empty", exp_q.size(), 0);

    // 5: reset in EXEC discards the writeback and clears registers
    check("t5_pc_rst", pc, 0);
    load(0, mvi(3'd5, 8'd9));
    pulse_start();
    repeat (2) @(posedge clk);
    do_reset();
    #1;
    check("t5_busy", busy, 0);
    check("t5_halted", halted, 0);
    load(0, mov(3'd3, 3'd5));
    load(1, mov(3'd4, 3'd0));
    load(2, ctl(8'hFF, 8'h00));
    exp_q.push_back({3'd3, 8'd0});
    exp_q.push_back({3'd4, 8'd0});
    pulse_start();
    wait_halt(n_cyc);
    check("t5_pc", pc, 2);
    check("t5_queue_empty", exp_q.size(), 0);

    // 6: SUB to zero then JZ 10
    load(0, mvi(3'd0, 8'd7));
    load(1, mvi(3'd1, 8'd7));
    load(2, alu(3'b001, 3'd1));
    load(3, ctl(8'hC8, 8'd10));
    load(4, ctl(8'hFF, 8'h00));
    load(10, mvi(3'd6, 8'h11));
    load(11, ctl(8'hFF, 8'h00));
    exp_q.push_back({3'd0, 8'd7});
    exp_q.push_back({3'd1, 8'd7});
    exp_q.push_back({3'd0, 8'd0});
`ifdef MC_CPU_FLAGS_EN
    exp_q.push_back({3'd6, 8'h11});
`endif
    pulse_start();
    wait_halt(n_cyc);
`ifdef MC_CPU_FLAGS_EN
    check("t6_pc_jz_taken", pc, 11);
`else
    check("t6_pc_jz_nop", pc, 4);
`endif
    repeat (2) @(posedge clk);
    #1 check("t6_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
